// File: rtl/flow_cfg_pkg.sv
// Shared constants for the flow-config register block: sizing, register map,
// control/status bit positions and commit FSM state encoding.
package flow_cfg_pkg;

  localparam int N_FLOWS    = 256;
  localparam int N_MGRS     = 4;
  localparam int ADDR_WIDTH = 8;
  localparam int PAY_WIDTH  = 8;
  localparam int FLOW_WIDTH = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1;
  localparam int MGR_WIDTH  = (N_MGRS > 1) ? $clog2(N_MGRS) : 1;

  localparam logic [ADDR_WIDTH-1:0] REG_CTRL    = ADDR_WIDTH'('h00);
  localparam logic [ADDR_WIDTH-1:0] REG_STATUS  = ADDR_WIDTH'('h04);
  localparam logic [ADDR_WIDTH-1:0] REG_DMAC_LO = ADDR_WIDTH'('h08);
  localparam logic [ADDR_WIDTH-1:0] REG_DMAC_HI = ADDR_WIDTH'('h0C);
  localparam logic [ADDR_WIDTH-1:0] REG_SMAC_LO = ADDR_WIDTH'('h10);
  localparam logic [ADDR_WIDTH-1:0] REG_SMAC_HI = ADDR_WIDTH'('h14);
  localparam logic [ADDR_WIDTH-1:0] REG_ETYPE   = ADDR_WIDTH'('h18);
  localparam logic [ADDR_WIDTH-1:0] REG_PAYLOAD = ADDR_WIDTH'('h1C);
  localparam logic [ADDR_WIDTH-1:0] REG_LEN     = ADDR_WIDTH'('h20);
  localparam logic [ADDR_WIDTH-1:0] REG_FLOW_ID = ADDR_WIDTH'('h24);
  localparam logic [ADDR_WIDTH-1:0] REG_MGR_SEL = ADDR_WIDTH'('h28);

  localparam int CTRL_COMMIT     = 0;
  localparam int CTRL_CLR_ERR    = 1;
  localparam int STATUS_BUSY     = 0;
  localparam int STATUS_ID_ERR   = 1;
  localparam int STATUS_OVERRUN  = 2;
  localparam int STATUS_CNT_LSB  = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } commit_state_e;

  // Expands the 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/flow_cfg_regs_if.sv
// Register bus plus the per-manager commit channel of the flow-config block.
interface flow_cfg_regs_if;
  import flow_cfg_pkg::*;

  logic [ADDR_WIDTH-1:0] reg_wr_addr;
  logic [31:0]           reg_wr_data;
  logic [3:0]            reg_wr_strb;
  logic                  reg_wr_en;
  logic                  reg_wr_wait;
  logic                  reg_wr_ack;
  logic [ADDR_WIDTH-1:0] reg_rd_addr;
  logic                  reg_rd_en;
  logic [31:0]           reg_rd_data;
  logic                  reg_rd_wait;
  logic                  reg_rd_ack;

  // Commit handshake: cfg_valid[m] rises with cfg_* already stable and stays
  // high (payload frozen) until the cycle cfg_ready[m] is sampled high; that
  // edge is the transfer. Only the selected manager's ready is looked at.
  logic [N_MGRS-1:0]     cfg_valid;
  logic [N_MGRS-1:0]     cfg_ready;
  logic [FLOW_WIDTH-1:0] cfg_id;
  logic [47:0]           cfg_d_mac;
  logic [47:0]           cfg_s_mac;
  logic [15:0]           cfg_ethertype;
  logic [PAY_WIDTH-1:0]  cfg_payload;
  logic [10:0]           cfg_len;

  modport slave (
    input  reg_wr_addr, reg_wr_data, reg_wr_strb, reg_wr_en,
    input  reg_rd_addr, reg_rd_en, cfg_ready,
    output reg_wr_wait, reg_wr_ack, reg_rd_data, reg_rd_wait, reg_rd_ack,
    output cfg_valid, cfg_id, cfg_d_mac, cfg_s_mac, cfg_ethertype, cfg_payload, cfg_len
  );

  modport master (
    output reg_wr_addr, reg_wr_data, reg_wr_strb, reg_wr_en,
    output reg_rd_addr, reg_rd_en, cfg_ready,
    input  reg_wr_wait, reg_wr_ack, reg_rd_data, reg_rd_wait, reg_rd_ack,
    input  cfg_valid, cfg_id, cfg_d_mac, cfg_s_mac, cfg_ethertype, cfg_payload, cfg_len
  );

endinterface

// File: rtl/flow_cfg_commit_fsm.sv
// Commit engine: validates a commit request, snapshots the shadow set onto the
// output bus and holds it on one manager channel until that manager accepts.
module flow_cfg_commit_fsm import flow_cfg_pkg::*; (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  commit_i,
  input  logic                  clr_err_i,
  input  logic [31:0]           flow_id_i,
  input  logic [MGR_WIDTH-1:0]  mgr_sel_i,
  input  logic [47:0]           d_mac_i,
  input  logic [47:0]           s_mac_i,
  input  logic [15:0]           etype_i,
  input  logic [PAY_WIDTH-1:0]  payload_i,
  input  logic [10:0]           len_i,
  input  logic [N_MGRS-1:0]     cfg_ready_i,
  output logic [N_MGRS-1:0]     cfg_valid_o,
  output logic [FLOW_WIDTH-1:0] cfg_id_o,
  output logic [47:0]           cfg_d_mac_o,
  output logic [47:0]           cfg_s_mac_o,
  output logic [15:0]           cfg_ethertype_o,
  output logic [PAY_WIDTH-1:0]  cfg_payload_o,
  output logic [10:0]           cfg_len_o,
  output logic                  id_err_o,
  output logic                  overrun_o,
  output logic [7:0]            commit_cnt_o,
  output commit_state_e         state_o
);

  commit_state_e         state_q, state_d;
  logic [N_MGRS-1:0]     valid_q, valid_d;
  logic [MGR_WIDTH-1:0]  sel_q, sel_d;
  logic                  id_err_q, id_err_d;
  logic                  ovr_q, ovr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  load;
  logic                  bad_cfg;

  logic [FLOW_WIDTH-1:0] id_q;
  logic [47:0]           dmac_q;
  logic [47:0]           smac_q;
  logic [15:0]           etype_q;
  logic [PAY_WIDTH-1:0]  pay_q;
  logic [10:0]           len_q;

  assign bad_cfg = (flow_id_i >= 32'(N_FLOWS)) || (32'(mgr_sel_i) >= 32'(N_MGRS));

  // Error clears happen before the commit is evaluated, so a combined
  // CLR_ERR|COMMIT write can re-raise an error in the same cycle.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    id_err_d = id_err_q & ~clr_err_i;
    ovr_d    = ovr_q & ~clr_err_i;
    case (state_q)
      ST_IDLE: begin
        if (commit_i) begin
          if (bad_cfg) begin
            id_err_d = 1'b1;
          end else begin
            load    = 1'b1;
            sel_d   = mgr_sel_i;
            valid_d = N_MGRS'(1) << mgr_sel_i;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (commit_i) ovr_d = 1'b1;
        if (cfg_ready_i[sel_q]) begin
          valid_d = '0;
          cnt_d   = cnt_q + 8'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      valid_q  <= '0;
      sel_q    <= '0;
      id_err_q <= 1'b0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      sel_q    <= sel_d;
      id_err_q <= id_err_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q    <= '0;
      dmac_q  <= '0;
      smac_q  <= '0;
      etype_q <= '0;
      pay_q   <= '0;
      len_q   <= '0;
    end else if (load) begin
      id_q    <= flow_id_i[FLOW_WIDTH-1:0];
      dmac_q  <= d_mac_i;
      smac_q  <= s_mac_i;
      etype_q <= etype_i;
      pay_q   <= payload_i;
      len_q   <= len_i;
    end
  end

  assign cfg_valid_o     = valid_q;
  assign cfg_id_o        = id_q;
  assign cfg_d_mac_o     = dmac_q;
  assign cfg_s_mac_o     = smac_q;
  assign cfg_ethertype_o = etype_q;
  assign cfg_payload_o   = pay_q;
  assign cfg_len_o       = len_q;
  assign id_err_o        = id_err_q;
  assign overrun_o       = ovr_q;
  assign commit_cnt_o    = cnt_q;
  assign state_o         = state_q;

endmodule

// File: rtl/flow_cfg_regs.sv
// Flow-config register slave: byte-strobed shadow registers, readback decode,
// and the commit engine that publishes the shadow set to a traffic manager.
module flow_cfg_regs import flow_cfg_pkg::*; (
  input  logic            clk,
  input  logic            rst_n,
  flow_cfg_regs_if.slave  bus
);

  logic [47:0]          dmac_q, dmac_d;
  logic [47:0]          smac_q, smac_d;
  logic [15:0]          etype_q, etype_d;
  logic [PAY_WIDTH-1:0] pay_q, pay_d;
  logic [10:0]          len_q, len_d;
  logic [31:0]          flow_id_q, flow_id_d;
  logic [MGR_WIDTH-1:0] mgr_sel_q, mgr_sel_d;

  logic                 wr_ack_q;
  logic                 rd_ack_q;
  logic [31:0]          rd_data_q;
  logic [31:0]          rd_word;

  logic [31:0]          wmask;
  logic [31:0]          wdata;
  logic                 ctrl_wr;
  logic                 commit;
  logic                 clr_err;

  logic                 id_err;
  logic                 overrun;
  logic [7:0]           commit_cnt;
  commit_state_e        fsm_state;
  logic                 busy;

  assign wmask   = byte_mask(bus.reg_wr_strb);
  assign wdata   = bus.reg_wr_data;
  assign ctrl_wr = bus.reg_wr_en && (bus.reg_wr_addr == REG_CTRL) && bus.reg_wr_strb[0];
  assign commit  = ctrl_wr && wdata[CTRL_COMMIT];
  assign clr_err = ctrl_wr && wdata[CTRL_CLR_ERR];
  assign busy    = (fsm_state == ST_ISSUE);

  // Each field keeps only its own low bits; upper bytes of the bus are dropped.
  always_comb begin
    dmac_d    = dmac_q;
    smac_d    = smac_q;
    etype_d   = etype_q;
    pay_d     = pay_q;
    len_d     = len_q;
    flow_id_d = flow_id_q;
    mgr_sel_d = mgr_sel_q;
    if (bus.reg_wr_en) begin
      case (bus.reg_wr_addr)
        REG_DMAC_LO: dmac_d[31:0]  = (dmac_q[31:0] & ~wmask) | (wdata & wmask);
        REG_DMAC_HI: dmac_d[47:32] = (dmac_q[47:32] & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
        REG_SMAC_LO: smac_d[31:0]  = (smac_q[31:0] & ~wmask) | (wdata & wmask);
        REG_SMAC_HI: smac_d[47:32] = (smac_q[47:32] & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
        REG_ETYPE:   etype_d       = (etype_q & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
        REG_PAYLOAD: pay_d         = (pay_q & ~wmask[PAY_WIDTH-1:0]) |
                                     (wdata[PAY_WIDTH-1:0] & wmask[PAY_WIDTH-1:0]);
        REG_LEN:     len_d         = (len_q & ~wmask[10:0]) | (wdata[10:0] & wmask[10:0]);
        REG_FLOW_ID: flow_id_d     = (flow_id_q & ~wmask) | (wdata & wmask);
        REG_MGR_SEL: mgr_sel_d     = (mgr_sel_q & ~wmask[MGR_WIDTH-1:0]) |
                                     (wdata[MGR_WIDTH-1:0] & wmask[MGR_WIDTH-1:0]);
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    case (bus.reg_rd_addr)
      REG_STATUS: begin
        rd_word[STATUS_BUSY]                      = busy;
        rd_word[STATUS_ID_ERR]                    = id_err;
        rd_word[STATUS_OVERRUN]                   = overrun;
        rd_word[STATUS_CNT_LSB+7:STATUS_CNT_LSB]  = commit_cnt;
      end
      REG_DMAC_LO: rd_word = dmac_q[31:0];
      REG_DMAC_HI: rd_word = 32'(dmac_q[47:32]);
      REG_SMAC_LO: rd_word = smac_q[31:0];
      REG_SMAC_HI: rd_word = 32'(smac_q[47:32]);
      REG_ETYPE:   rd_word = 32'(etype_q);
      REG_PAYLOAD: rd_word = 32'(pay_q);
      REG_LEN:     rd_word = 32'(len_q);
      REG_FLOW_ID: rd_word = flow_id_q;
      REG_MGR_SEL: rd_word = 32'(mgr_sel_q);
      default:     rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmac_q    <= '0;
      smac_q    <= '0;
      etype_q   <= '0;
      pay_q     <= '0;
      len_q     <= '0;
      flow_id_q <= '0;
      mgr_sel_q <= '0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      dmac_q    <= dmac_d;
      smac_q    <= smac_d;
      etype_q   <= etype_d;
      pay_q     <= pay_d;
      len_q     <= len_d;
      flow_id_q <= flow_id_d;
      mgr_sel_q <= mgr_sel_d;
      wr_ack_q  <= bus.reg_wr_en;
      rd_ack_q  <= bus.reg_rd_en;
      if (bus.reg_rd_en) rd_data_q <= rd_word;
    end
  end

  assign bus.reg_wr_wait = 1'b0;
  assign bus.reg_rd_wait = 1'b0;
  assign bus.reg_wr_ack  = wr_ack_q;
  assign bus.reg_rd_ack  = rd_ack_q;
  assign bus.reg_rd_data = rd_data_q;

  flow_cfg_commit_fsm u_commit (
    .clk             (clk),
    .rst_n           (rst_n),
    .commit_i        (commit),
    .clr_err_i       (clr_err),
    .flow_id_i       (flow_id_q),
    .mgr_sel_i       (mgr_sel_q),
    .d_mac_i         (dmac_q),
    .s_mac_i         (smac_q),
    .etype_i         (etype_q),
    .payload_i       (pay_q),
    .len_i           (len_q),
    .cfg_ready_i     (bus.cfg_ready),
    .cfg_valid_o     (bus.cfg_valid),
    .cfg_id_o        (bus.cfg_id),
    .cfg_d_mac_o     (bus.cfg_d_mac),
    .cfg_s_mac_o     (bus.cfg_s_mac),
    .cfg_ethertype_o (bus.cfg_ethertype),
    .cfg_payload_o   (bus.cfg_payload),
    .cfg_len_o       (bus.cfg_len),
    .id_err_o        (id_err),
    .overrun_o       (overrun),
    .commit_cnt_o    (commit_cnt),
    .state_o         (fsm_state)
  );

endmodule
